// File: rtl/ex_mem_cond_stage_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ex_mem_cond_stage_pkg : shared pipeline types and flag/condition constants
// Revision 1.0
// ----------------------------------------------------------------------------
package ex_mem_cond_stage_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;

endpackage : ex_mem_cond_stage_pkg
`default_nettype wire

// File: rtl/ex_mem_cond_stage_cond_check.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ex_mem_cond_stage_cond_check : combinational ARM condition-field evaluator
// Revision 1.0
// ----------------------------------------------------------------------------
module ex_mem_cond_stage_cond_check
  import ex_mem_cond_stage_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_pass
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = i_flags[FLAG_N];
  assign w_z = i_flags[FLAG_Z];
  assign w_c = i_flags[FLAG_C];
  assign w_v = i_flags[FLAG_V];

  always_comb begin
    o_pass = 1'b0;
    case (cond_e'(i_cond))
      COND_EQ: o_pass = w_z;
      COND_NE: o_pass = !w_z;
      COND_CS: o_pass = w_c;
      COND_CC: o_pass = !w_c;
      COND_MI: o_pass = w_n;
      COND_PL: o_pass = !w_n;
      COND_VS: o_pass = w_v;
      COND_VC: o_pass = !w_v;
      COND_HI: o_pass = w_c && !w_z;
      COND_LS: o_pass = !w_c || w_z;
      COND_GE: o_pass = (w_n == w_v);
      COND_LT: o_pass = (w_n != w_v);
      COND_GT: o_pass = !w_z && (w_n == w_v);
      COND_LE: o_pass = w_z || (w_n != w_v);
      COND_AL: o_pass = 1'b1;
      // NV is architecturally "never" here
      default: o_pass = 1'b0;
    endcase
  end

endmodule : ex_mem_cond_stage_cond_check
`default_nettype wire

// File: rtl/ex_mem_cond_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ex_mem_cond_stage : EX/MEM boundary with condition evaluation, NZCV commit,
//                     stall/flush control and saturating bring-up counters
// Revision 1.0
// ----------------------------------------------------------------------------
module ex_mem_cond_stage
  import ex_mem_cond_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 4,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ex_valid,
  input  logic [DATA_W-1:0]  ex_result,
  input  logic [3:0]         ex_flags,
  input  logic [3:0]         ex_cond,
  input  logic [1:0]         ex_flag_write,
  input  logic               ex_reg_write,
  input  logic               ex_mem_write,
  input  logic               ex_pc_src,
  input  logic [REG_W-1:0]   ex_rd,
  input  logic [DATA_W-1:0]  ex_write_data,
  input  logic               stall,
  input  logic               flush,
  output logic               cond_ex,
  output logic [3:0]         flags_q,
  output logic               mem_valid,
  output logic               mem_reg_write,
  output logic               mem_mem_write,
  output logic               mem_pc_src,
  output logic [DATA_W-1:0]  mem_result,
  output logic [DATA_W-1:0]  mem_write_data,
  output logic [REG_W-1:0]   mem_rd,
  output logic [COUNT_W-1:0] cnt_exec,
  output logic [COUNT_W-1:0] cnt_skip
);

  logic               w_pass;
  logic               w_advance;
  logic               w_exec;
  logic               w_skip;

  logic [3:0]         r_flags;
  logic               r_valid;
  logic               r_reg_write;
  logic               r_mem_write;
  logic               r_pc_src;
  logic [DATA_W-1:0]  r_result;
  logic [DATA_W-1:0]  r_write_data;
  logic [REG_W-1:0]   r_rd;
  logic [COUNT_W-1:0] r_cnt_exec;
  logic [COUNT_W-1:0] r_cnt_skip;

  // Evaluated against committed flags so a flag-setting op followed directly
  // by a conditional op sees the freshly committed value without a bubble.
  ex_mem_cond_stage_cond_check u_cond_check (
    .i_cond  (ex_cond),
    .i_flags (r_flags),
    .o_pass  (w_pass)
  );

  assign cond_ex   = ex_valid & w_pass;
  assign w_advance = !stall && !flush;
  assign w_exec    = w_advance && cond_ex;
  assign w_skip    = w_advance && ex_valid && !cond_ex;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flags      <= 4'b0000;
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_pc_src     <= 1'b0;
      r_result     <= '0;
      r_write_data <= '0;
      r_rd         <= '0;
    end else if (flush) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_write <= 1'b0;
      r_pc_src    <= 1'b0;
    end else if (!stall) begin
      r_valid      <= cond_ex;
      r_reg_write  <= ex_reg_write & cond_ex;
      r_mem_write  <= ex_mem_write & cond_ex;
      r_pc_src     <= ex_pc_src & cond_ex;
      r_result     <= ex_result;
      r_write_data <= ex_write_data;
      r_rd         <= ex_rd;
      if (cond_ex && ex_flag_write[FW_NZ]) begin
        r_flags[FLAG_N] <= ex_flags[FLAG_N];
        r_flags[FLAG_Z] <= ex_flags[FLAG_Z];
      end
      if (cond_ex && ex_flag_write[FW_CV]) begin
        r_flags[FLAG_C] <= ex_flags[FLAG_C];
        r_flags[FLAG_V] <= ex_flags[FLAG_V];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt_exec <= '0;
      r_cnt_skip <= '0;
    end else begin
      if (w_exec && (r_cnt_exec != '1)) begin
        r_cnt_exec <= r_cnt_exec + COUNT_W'(1);
      end
      if (w_skip && (r_cnt_skip != '1)) begin
        r_cnt_skip <= r_cnt_skip + COUNT_W'(1);
      end
    end
  end

  assign flags_q        = r_flags;
  assign mem_valid      = r_valid;
  assign mem_reg_write  = r_reg_write;
  assign mem_mem_write  = r_mem_write;
  assign mem_pc_src     = r_pc_src;
  assign mem_result     = r_result;
  assign mem_write_data = r_write_data;
  assign mem_rd         = r_rd;
  assign cnt_exec       = r_cnt_exec;
  assign cnt_skip       = r_cnt_skip;

endmodule : ex_mem_cond_stage
`default_nettype wire
